// File: rtl/mac_pkg.sv
// Shared definitions for the lane-parallel MAC: width helpers, saturation
// limits for the default configuration and the frame FSM state encoding.
package mac_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Width of one lane product: signed (w+1) x signed (w).
  function automatic int prod_width(input int w);
    return 2 * w + 1;
  endfunction

  // Width of the cross-lane sum; wide enough that it can never overflow.
  function automatic int sum_width(input int w, input int lanes);
    return prod_width(w) + clog2(lanes);
  endfunction

  localparam int DEF_BW        = 4;
  localparam int DEF_PSUM_BW   = 16;
  localparam int DEF_NUM_LANES = 4;

  localparam int PROD_W = 2 * DEF_BW + 1;
  localparam int SUM_W  = PROD_W + clog2(DEF_NUM_LANES);

  localparam logic signed [DEF_PSUM_BW-1:0] SAT_MAX = {1'b0, {(DEF_PSUM_BW-1){1'b1}}};
  localparam logic signed [DEF_PSUM_BW-1:0] SAT_MIN = {1'b1, {(DEF_PSUM_BW-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } frame_state_t;

endpackage

// File: rtl/mac_lane_mul.sv
// One lane multiplier: activation (signed or unsigned, chosen per beat)
// times a signed weight. Purely combinational; the caller registers it.
module mac_lane_mul
  import mac_pkg::*;
#(
  parameter int BW = 4
) (
  input  logic                              i_act,
  input  logic [BW-1:0]                     i_act_bits,
  input  logic [BW-1:0]                     i_wgt,
  output logic signed [prod_width(BW)-1:0]  o_prod
);

  localparam int PW = prod_width(BW);

  logic signed [BW:0]   w_act_ext;
  logic signed [BW-1:0] w_wgt;
  logic signed [PW-1:0] w_act_wide;
  logic signed [PW-1:0] w_wgt_wide;

  // i_act selects the activation format: extending with the top bit only
  // when signed makes the same (BW+1)-bit signed multiply serve both modes.
  assign w_act_ext  = {i_act & i_act_bits[BW-1], i_act_bits};
  assign w_wgt      = i_wgt;
  assign w_act_wide = PW'(w_act_ext);
  assign w_wgt_wide = PW'(w_wgt);
  assign o_prod     = w_act_wide * w_wgt_wide;

endmodule

// File: rtl/mac_lane_acc.sv
// NUM_LANES-wide dot product per beat, accumulated across a framed sequence
// of beats into a saturating signed partial sum.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | between frames; only a beat flagged first is accepted
//   ST_ACC  | inside a frame; every valid beat is accepted, a first
//           | beat restarts the frame and flags a protocol error
//
// Pipeline: S1 = lane products, S2 = lane sum, S3 = accumulator/outputs.
// Flags ride with the data, so frames may overlap in flight.
module mac_lane_acc
  import mac_pkg::*;
#(
  parameter int bw        = DEF_BW,
  parameter int psum_bw   = DEF_PSUM_BW,
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_first,
  input  logic                      in_last,
  input  logic                      act_signed,
  input  logic [NUM_LANES*bw-1:0]   act,
  input  logic [NUM_LANES*bw-1:0]   wgt,
  output logic                      out_valid,
  output logic [psum_bw-1:0]        out_psum,
  output logic                      out_sat,
  output logic                      err
);

  localparam int PW = prod_width(bw);
  localparam int SW = sum_width(bw, NUM_LANES);

  // Clamp limits expressed in the one-bit-wider accumulation width.
  localparam logic signed [psum_bw:0] ACC_MAX = {2'b00, {(psum_bw-1){1'b1}}};
  localparam logic signed [psum_bw:0] ACC_MIN = {2'b11, {(psum_bw-1){1'b0}}};

  frame_state_t r_state;
  logic         r_err;
  logic         w_accept;
  logic         w_proto_err;

  logic signed [PW-1:0] w_prod [NUM_LANES];

  logic signed [PW-1:0] r_s1_prod [NUM_LANES];
  logic                 r_s1_vld;
  logic                 r_s1_first;
  logic                 r_s1_last;

  logic signed [SW-1:0] w_lane_sum;
  logic signed [SW-1:0] r_s2_sum;
  logic                 r_s2_vld;
  logic                 r_s2_first;
  logic                 r_s2_last;

  logic signed [psum_bw-1:0] r_acc;
  logic                      r_sat;
  logic signed [psum_bw:0]   w_base;
  logic signed [psum_bw:0]   w_sum_ext;
  logic signed [psum_bw:0]   w_total;
  logic signed [psum_bw-1:0] w_clamped;
  logic                      w_clip;
  logic                      w_sat_next;

  logic                 r_out_valid;
  logic [psum_bw-1:0]   r_out_psum;
  logic                 r_out_sat;

  // Beat acceptance and protocol-violation decode for the current state.
  always_comb begin
    w_accept    = in_valid & (in_first | (r_state == ST_ACC));
    w_proto_err = 1'b0;
    if (in_valid) begin
      if (r_state == ST_IDLE) w_proto_err = ~in_first;
      else                    w_proto_err = in_first;
    end
  end

  // Frame FSM with registered error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_proto_err;
      if (w_accept) r_state <= in_last ? ST_IDLE : ST_ACC;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      mac_lane_mul #(.BW(bw)) u_mul (
        .i_act      (act_signed),
        .i_act_bits (act[g*bw +: bw]),
        .i_wgt      (wgt[g*bw +: bw]),
        .o_prod     (w_prod[g])
      );
    end
  endgenerate

  // S1: capture lane products and frame flags of accepted beats only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) r_s1_prod[i] <= '0;
    end else begin
      r_s1_vld   <= w_accept;
      r_s1_first <= w_accept & in_first;
      r_s1_last  <= w_accept & in_last;
      if (w_accept) begin
        for (int i = 0; i < NUM_LANES; i++) r_s1_prod[i] <= w_prod[i];
      end
    end
  end

  // Cross-lane sum of the registered products (sign-extended to SW bits).
  always_comb begin
    w_lane_sum = '0;
    for (int i = 0; i < NUM_LANES; i++) w_lane_sum = w_lane_sum + SW'(r_s1_prod[i]);
  end

  // S2: register the lane sum and forward the flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_sum   <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
    end else begin
      r_s2_vld   <= r_s1_vld;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      if (r_s1_vld) r_s2_sum <= w_lane_sum;
    end
  end

  // Next accumulator value with clamp; a first beat starts from zero.
  always_comb begin
    w_base     = r_s2_first ? '0 : (psum_bw+1)'(r_acc);
    w_sum_ext  = (psum_bw+1)'(r_s2_sum);
    w_total    = w_base + w_sum_ext;
    w_clip     = 1'b0;
    w_clamped  = w_total[psum_bw-1:0];
    if (w_total > ACC_MAX) begin
      w_clamped = ACC_MAX[psum_bw-1:0];
      w_clip    = 1'b1;
    end else if (w_total < ACC_MIN) begin
      w_clamped = ACC_MIN[psum_bw-1:0];
      w_clip    = 1'b1;
    end
    w_sat_next = (r_s2_first ? 1'b0 : r_sat) | w_clip;
  end

  // S3: update accumulator and sticky sat; publish the result on a last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_psum  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_out_valid <= r_s2_vld & r_s2_last;
      if (r_s2_vld) begin
        r_acc <= w_clamped;
        r_sat <= w_sat_next;
        if (r_s2_last) begin
          r_out_psum <= w_clamped;
          r_out_sat  <= w_sat_next;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_psum  = r_out_psum;
  assign out_sat   = r_out_sat;
  assign err       = r_err;

endmodule

// File: tb/tb_mac_lane_acc.sv
module tb_mac_lane_acc;

  localparam int BW      = 4;
  localparam int PSUM_BW = 16;
  localparam int NL      = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_first, in_last, act_signed;
  logic [15:0] act, wgt;
  logic        out_valid;
  logic [15:0] out_psum;
  logic        out_sat;
  logic        err;

  mac_lane_acc #(.bw(BW), .psum_bw(PSUM_BW), .NUM_LANES(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_first   (in_first),
    .in_last    (in_last),
    .act_signed (act_signed),
    .act        (act),
    .wgt        (wgt),
    .out_valid  (out_valid),
    .out_psum   (out_psum),
    .out_sat    (out_sat),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int drive_cyc    = 0;

  logic [15:0] got_psum[$];
  logic        got_sat[$];
  int          got_cyc[$];
  int          err_seen = 0;

  int exp_psum[$];
  bit exp_sat[$];
  int exp_err = 0;
  int m_acc   = 0;
  bit m_sat   = 0;
  bit m_busy  = 0;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      got_psum.push_back(out_psum);
      got_sat.push_back(out_sat);
      got_cyc.push_back(cyc);
    end
    if (err === 1'b1) err_seen++;
  end

  // Frame-level reference: integer dot product, running sum, clamp.
  function automatic int dot(input logic [15:0] a, input logic [15:0] w, input bit s);
    int sum;
    logic [3:0] la, lw;
    sum = 0;
    for (int i = 0; i < NL; i++) begin
      la = a[i*BW +: BW];
      lw = w[i*BW +: BW];
      sum += (s ? int'($signed(la)) : int'(la)) * int'($signed(lw));
    end
    return sum;
  endfunction

  task automatic model_beat(input bit v, f, l, s, input logic [15:0] a, w);
    if (!v) return;
    if (!m_busy && !f) begin
      exp_err++;
      return;
    end
    if (m_busy && f) exp_err++;
    if (f) begin
      m_acc = 0;
      m_sat = 0;
    end
    m_acc += dot(a, w, s);
    if (m_acc > 32767) begin
      m_acc = 32767;
      m_sat = 1;
    end else if (m_acc < -32768) begin
      m_acc = -32768;
      m_sat = 1;
    end
    if (l) begin
      exp_psum.push_back(m_acc);
      exp_sat.push_back(m_sat);
      m_busy = 0;
    end else begin
      m_busy = 1;
    end
  endtask

  task automatic model_reset();
    m_acc  = 0;
    m_sat  = 0;
    m_busy = 0;
  endtask

  task automatic drive(input bit v, f, l, s, input logic [15:0] a, w);
    @(negedge clk);
    in_valid   = v;
    in_first   = f;
    in_last    = l;
    act_signed = s;
    act        = a;
    wgt        = w;
    drive_cyc  = cyc;
    model_beat(v, f, l, s, a, w);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic clear_obs();
    got_psum.delete();
    got_sat.delete();
    got_cyc.delete();
    exp_psum.delete();
    exp_sat.delete();
    err_seen = 0;
    exp_err  = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (out_psum !== 16'h0000) begin tests_failed++; $display("FAIL reset_psum: got %h expected 0000", out_psum); end
    tests_run++;
    if (out_sat !== 1'b0) begin tests_failed++; $display("FAIL reset_sat: got %b expected 0", out_sat); end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", err); end
    #2 reset = 1'b1;
    clear_obs();
    idle(4);
    tests_run++;
    if (got_psum.size() != 0 || err_seen != 0) begin
      tests_failed++;
      $display("FAIL reset_quiet: got %0d outputs %0d errs expected 0 0", got_psum.size(), err_seen);
    end
  endtask

  task automatic test_single_beat();
    int t0;
    clear_obs();
    drive(1, 1, 1, 0, 16'h4321, 16'hE2F1);
    t0 = drive_cyc;
    idle(6);
    tests_run++;
    if (got_psum.size() != 1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", got_psum.size()); end
    if (got_psum.size() > 0) begin
      tests_run++;
      if (got_psum[0] !== 16'hFFFD) begin tests_failed++; $display("FAIL single_psum: got %h expected FFFD", got_psum[0]); end
      tests_run++;
      if (got_sat[0] !== 1'b0) begin tests_failed++; $display("FAIL single_sat: got %b expected 0", got_sat[0]); end
      tests_run++;
      if (got_cyc[0] - t0 != 3) begin tests_failed++; $display("FAIL single_latency: got %0d expected 3", got_cyc[0] - t0); end
    end
    tests_run++;
    if (err_seen != 0) begin tests_failed++; $display("FAIL single_err: got %0d expected 0", err_seen); end
  endtask

  task automatic test_long_frame();
    int t0;
    clear_obs();
    t0 = 0;
    for (int b = 0; b < 10; b++) begin
      drive(1, b == 0, b == 9, 0, 16'hFFFF, 16'h8888);
      if (b == 9) t0 = drive_cyc;
      if (b == 4) idle(1);
    end
    idle(6);
    tests_run++;
    if (got_psum.size() != 1) begin tests_failed++; $display("FAIL long_count: got %0d expected 1", got_psum.size()); end
    if (got_psum.size() > 0) begin
      tests_run++;
      if (got_psum[0] !== 16'hED40) begin tests_failed++; $display("FAIL long_psum: got %h expected ED40", got_psum[0]); end
      tests_run++;
      if (got_sat[0] !== 1'b0) begin tests_failed++; $display("FAIL long_sat: got %b expected 0", got_sat[0]); end
      tests_run++;
      if (got_cyc[0] - t0 != 3) begin tests_failed++; $display("FAIL long_latency: got %0d expected 3", got_cyc[0] - t0); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_p [3];
    logic        exp_s [3];
    clear_obs();
    exp_p = '{16'h7FFF, 16'h0001, 16'h8000};
    exp_s = '{1'b1, 1'b0, 1'b1};
    for (int b = 0; b < 79; b++) drive(1, b == 0, b == 78, 0, 16'hFFFF, 16'h7777);
    drive(1, 1, 1, 0, 16'h0001, 16'h0001);
    for (int b = 0; b < 70; b++) drive(1, b == 0, b == 69, 0, 16'hFFFF, 16'h8888);
    idle(6);
    tests_run++;
    if (got_psum.size() != 3) begin tests_failed++; $display("FAIL sat_count: got %0d expected 3", got_psum.size()); end
    for (int i = 0; i < 3 && i < got_psum.size(); i++) begin
      tests_run++;
      if (got_psum[i] !== exp_p[i]) begin tests_failed++; $display("FAIL sat_psum[%0d]: got %h expected %h", i, got_psum[i], exp_p[i]); end
      tests_run++;
      if (got_sat[i] !== exp_s[i]) begin tests_failed++; $display("FAIL sat_flag[%0d]: got %b expected %b", i, got_sat[i], exp_s[i]); end
    end
  endtask

  task automatic test_signed_mode();
    clear_obs();
    drive(1, 1, 1, 1, 16'hFFFF, 16'h3333);
    drive(1, 1, 1, 0, 16'hFFFF, 16'h3333);
    idle(6);
    tests_run++;
    if (got_psum.size() != 2) begin tests_failed++; $display("FAIL signed_count: got %0d expected 2", got_psum.size()); end
    if (got_psum.size() > 1) begin
      tests_run++;
      if (got_psum[0] !== 16'hFFF4) begin tests_failed++; $display("FAIL signed_psum: got %h expected FFF4", got_psum[0]); end
      tests_run++;
      if (got_psum[1] !== 16'h00B4) begin tests_failed++; $display("FAIL unsigned_psum: got %h expected 00B4", got_psum[1]); end
      tests_run++;
      if (got_cyc[1] - got_cyc[0] != 1) begin tests_failed++; $display("FAIL b2b_gap: got %0d expected 1", got_cyc[1] - got_cyc[0]); end
    end
  endtask

  task automatic test_protocol_err();
    clear_obs();
    drive(1, 0, 0, 0, 16'h1111, 16'h1111);
    idle(5);
    tests_run++;
    if (err_seen != 1) begin tests_failed++; $display("FAIL err_idle_pulse: got %0d expected 1", err_seen); end
    tests_run++;
    if (got_psum.size() != 0) begin tests_failed++; $display("FAIL err_idle_output: got %0d expected 0", got_psum.size()); end
    clear_obs();
    drive(1, 1, 0, 0, 16'($urandom), 16'($urandom));
    drive(1, 0, 0, 0, 16'($urandom), 16'($urandom));
    drive(1, 1, 1, 0, 16'h2222, 16'h3333);
    idle(6);
    tests_run++;
    if (err_seen != 1) begin tests_failed++; $display("FAIL err_restart_pulse: got %0d expected 1", err_seen); end
    tests_run++;
    if (got_psum.size() != 1) begin tests_failed++; $display("FAIL err_restart_count: got %0d expected 1", got_psum.size()); end
    if (got_psum.size() > 0) begin
      tests_run++;
      if (got_psum[0] !== 16'h0018) begin tests_failed++; $display("FAIL err_restart_psum: got %h expected 0018", got_psum[0]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    tests_run++;
    if (out_psum !== 16'h0018) begin tests_failed++; $display("FAIL hold_psum: got %h expected 0018", out_psum); end
    clear_obs();
    drive(1, 1, 0, 0, 16'hFFFF, 16'h7777);
    drive(1, 0, 0, 0, 16'hFFFF, 16'h7777);
    drive(1, 0, 0, 0, 16'hFFFF, 16'h7777);
    idle(1);
    #2 reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (out_psum !== 16'h0000) begin tests_failed++; $display("FAIL async_psum: got %h expected 0000", out_psum); end
    tests_run++;
    if (out_valid !== 1'b0 || err !== 1'b0) begin tests_failed++; $display("FAIL async_flags: got %b%b expected 00", out_valid, err); end
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    idle(6);
    drive(1, 0, 1, 0, 16'h1111, 16'h1111);
    idle(5);
    tests_run++;
    if (got_psum.size() != 0 || err_seen != 1) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got %0d outputs %0d errs expected 0 1", got_psum.size(), err_seen);
    end
    clear_obs();
    drive(1, 1, 1, 0, 16'h4321, 16'hE2F1);
    idle(1);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    idle(5);
    tests_run++;
    if (got_psum.size() != 0) begin tests_failed++; $display("FAIL inflight_drop: got %0d expected 0", got_psum.size()); end
    clear_obs();
    drive(1, 1, 1, 0, 16'h4321, 16'hE2F1);
    idle(6);
    tests_run++;
    if (got_psum.size() != 1) begin tests_failed++; $display("FAIL fresh_count: got %0d expected 1", got_psum.size()); end
    if (got_psum.size() > 0) begin
      tests_run++;
      if (got_psum[0] !== 16'hFFFD) begin tests_failed++; $display("FAIL fresh_psum: got %h expected FFFD", got_psum[0]); end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    clear_obs();
    for (int fr = 0; fr < 20; fr++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++)
        drive(1, b == 0, b == len - 1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    idle(6);
    tests_run++;
    if (got_psum.size() != exp_psum.size()) begin
      tests_failed++; $display("FAIL b2b_count: got %0d expected %0d", got_psum.size(), exp_psum.size());
    end
    for (int i = 0; i < exp_psum.size() && i < got_psum.size(); i++) begin
      tests_run++;
      if (got_psum[i] !== 16'(exp_psum[i]) || got_sat[i] !== exp_sat[i]) begin
        tests_failed++;
        $display("FAIL b2b_frame[%0d]: got %h/%b expected %h/%b", i, got_psum[i], got_sat[i], 16'(exp_psum[i]), exp_sat[i]);
      end
    end
    tests_run++;
    if (err_seen != exp_err) begin tests_failed++; $display("FAIL b2b_err: got %0d expected %0d", err_seen, exp_err); end
  endtask

  task automatic test_random();
    bit v, f, l, s;
    logic [15:0] a, w;
    clear_obs();
    for (int n = 0; n < 500; n++) begin
      v = ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 4) == 0);
      l = ($urandom_range(0, 5) == 0);
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        a = 16'hFFFF;
        w = $urandom_range(0, 1) ? 16'h7777 : 16'h8888;
      end else begin
        a = 16'($urandom);
        w = 16'($urandom);
      end
      drive(v, f, l, s, a, w);
    end
    idle(6);
    tests_run++;
    if (got_psum.size() != exp_psum.size()) begin
      tests_failed++; $display("FAIL rand_count: got %0d expected %0d", got_psum.size(), exp_psum.size());
    end
    for (int i = 0; i < exp_psum.size() && i < got_psum.size(); i++) begin
      tests_run++;
      if (got_psum[i] !== 16'(exp_psum[i]) || got_sat[i] !== exp_sat[i]) begin
        tests_failed++;
        $display("FAIL rand_frame[%0d]: got %h/%b expected %h/%b", i, got_psum[i], got_sat[i], 16'(exp_psum[i]), exp_sat[i]);
      end
    end
    tests_run++;
    if (err_seen != exp_err) begin tests_failed++; $display("FAIL rand_err: got %0d expected %0d", err_seen, exp_err); end
  endtask

  initial begin
    in_valid   = 1'b0;
    in_first   = 1'b0;
    in_last    = 1'b0;
    act_signed = 1'b0;
    act        = '0;
    wgt        = '0;
    reset      = 1'b1;
    #1 reset   = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_single_beat();
    test_long_frame();
    test_saturation();
    test_signed_mode();
    test_protocol_err();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
